// File: rtl/regfile_ctrl_pkg.sv
// Shared types and defaults for the register-file write arbiter.
package regfile_ctrl_pkg;

  localparam int ADDR_W_DEFAULT = 2;
  localparam int DATA_W_DEFAULT = 8;

  // Top-level control state: normal arbitration or zero-fill sweep.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Requester identity, also used as the round-robin priority pointer.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  // The requester that gets priority after the given one is served.
  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Bundle of the two requester handshakes, the clear-sweep control and the
// register-file write port. The arbiter sits on the slave side.
interface regfile_wr_arbiter_if #(
  parameter int ADDR_W = regfile_ctrl_pkg::ADDR_W_DEFAULT,
  parameter int DATA_W = regfile_ctrl_pkg::DATA_W_DEFAULT
);

  logic              req_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] data_a;
  logic              gnt_a;

  logic              req_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] data_b;
  logic              gnt_b;

  logic              clr_req;
  logic              busy;
  logic              clr_done;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  modport master (
    output req_a, addr_a, data_a,
    output req_b, addr_b, data_b,
    output clr_req,
    input  gnt_a, gnt_b, busy, clr_done,
    input  we, waddr, wdata
  );

  modport slave (
    input  req_a, addr_a, data_a,
    input  req_b, addr_b, data_b,
    input  clr_req,
    output gnt_a, gnt_b, busy, clr_done,
    output we, waddr, wdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Grants are combinational from the eligible
// requests; the priority pointer moves to the other requester after any grant
// and holds otherwise (idle cycles, or while en is low).
module rr_arb2
  import regfile_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  req_id_t ptr;

  // Pick a winner: single requester wins outright, a tie goes to the pointer.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      if (req_a && req_b) begin
        if (ptr == REQ_A) gnt_a = 1'b1;
        else              gnt_b = 1'b1;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  // Hand priority to the requester that was not just served.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= REQ_A;
    end else if (gnt_a) begin
      ptr <= other_req(REQ_A);
    end else if (gnt_b) begin
      ptr <= other_req(REQ_B);
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the register file: round-robin between two
// requesters, with a clear sweep that zero-fills every register and takes
// precedence over pending requests. All outputs are registered.
module regfile_wr_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  regfile_wr_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              armed;

  logic              we_q;
  logic              gnt_a_q;
  logic              gnt_b_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              elig_a;
  logic              elig_b;
  logic              start_clr;
  logic              arb_en;
  logic              win_a;
  logic              win_b;

  // A requester that is being granted this cycle still holds req high until
  // it sees gnt, so it is masked out to avoid a duplicate write.
  assign elig_a = bus.req_a & ~gnt_a_q;
  assign elig_b = bus.req_b & ~gnt_b_q;

  // armed delays the first decision after reset release by one edge; a clear
  // request landing on the clr_done cycle is dropped.
  assign start_clr = (state == IDLE) & armed & bus.clr_req & ~done_q;
  assign arb_en    = (state == IDLE) & armed & ~start_clr;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .req_a (elig_a),
    .req_b (elig_b),
    .gnt_a (win_a),
    .gnt_b (win_b)
  );

  // Control FSM: arbitration in IDLE, address sweep in CLEAR, registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      armed   <= 1'b0;
      we_q    <= 1'b0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      armed   <= 1'b1;
      we_q    <= 1'b0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      case (state)
        IDLE: begin
          if (start_clr) begin
            // First sweep write (address 0) is presented in the next cycle.
            state  <= CLEAR;
            cnt    <= '0;
            we_q   <= 1'b1;
            busy_q <= 1'b1;
          end else if (win_a) begin
            we_q    <= 1'b1;
            gnt_a_q <= 1'b1;
            waddr_q <= bus.addr_a;
            wdata_q <= bus.data_a;
          end else if (win_b) begin
            we_q    <= 1'b1;
            gnt_b_q <= 1'b1;
            waddr_q <= bus.addr_b;
            wdata_q <= bus.data_b;
          end
        end
        CLEAR: begin
          if (cnt == LAST_ADDR) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b1;
          end else begin
            cnt     <= cnt + ADDR_W'(1);
            we_q    <= 1'b1;
            busy_q  <= 1'b1;
            waddr_q <= cnt + ADDR_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign bus.gnt_a    = gnt_a_q;
  assign bus.gnt_b    = gnt_b_q;
  assign bus.busy     = busy_q;
  assign bus.clr_done = done_q;

  // At most one grant per cycle, and a grant always carries a write.
  a_gnt_onehot_we : assert property (
    @(posedge clk) disable iff (!rst)
      !(gnt_a_q && gnt_b_q) && (!(gnt_a_q || gnt_b_q) || we_q)
  );

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: table-driven request vectors,
// hand sequences for clear/reset corners, and a write scoreboard queue.
module tb_regfile_wr_arbiter;
  import regfile_ctrl_pkg::*;

  localparam int AW = 2;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  regfile_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register-file model fed by the write port.
  logic [DW-1:0] mem [4];
  always @(posedge clk) if (bus.we === 1'b1) mem[bus.waddr] <= bus.wdata;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          ga;
    logic          gb;
    logic          busy;
  } wr_t;

  typedef struct {
    logic          ra;
    logic [AW-1:0] aa;
    logic [DW-1:0] da;
    logic          rb;
    logic [AW-1:0] ab;
    logic [DW-1:0] db;
    logic          b_first;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[6];
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  int   busy_cnt = 0;

  function automatic wr_t mk_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic ga, input logic gb, input logic bz);
    wr_t w;
    w.addr = a; w.data = d; w.ga = ga; w.gb = gb; w.busy = bz;
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    wr_t e;
    if (rst !== 1'b1) return;
    if (bus.clr_done === 1'b1) done_cnt++;
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.gnt_a || bus.gnt_b) chk("gnt_onehot_we", {bus.gnt_a & bus.gnt_b, bus.we}, 32'h1);
    if (bus.we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: waddr=%0d wdata=0x%0h, expected no write at %0t",
                 bus.waddr, bus.wdata, $time);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", bus.waddr, e.addr);
        chk("wr_data", bus.wdata, e.data);
        chk("wr_gnt",  {bus.gnt_a, bus.gnt_b}, {e.ga, e.gb});
        chk("wr_busy", bus.busy, e.busy);
      end
    end else begin
      chk("idle_outputs", {bus.gnt_a, bus.gnt_b, bus.waddr, bus.wdata}, 32'h0);
    end
  endtask

  // One clock: sample mid-cycle, then return just after the next rising edge.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_a = 1'b0; bus.addr_a = '0; bus.data_a = '0;
    bus.req_b = 1'b0; bus.addr_b = '0; bus.data_b = '0;
    bus.clr_req = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {bus.we, bus.gnt_a, bus.gnt_b, bus.busy, bus.clr_done, bus.waddr, bus.wdata}, 32'h0);
  endtask

  // Reset pulse; returns just after the first edge following release.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    #1;
    chk_reset_outputs("reset_outputs");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    wr_t wa, wb;
    wa = mk_wr(v.aa, v.da, 1'b1, 1'b0, 1'b0);
    wb = mk_wr(v.ab, v.db, 1'b0, 1'b1, 1'b0);
    if (v.ra && v.rb) begin
      if (v.b_first) begin exp_q.push_back(wb); exp_q.push_back(wa); end
      else begin exp_q.push_back(wa); exp_q.push_back(wb); end
    end else if (v.ra) exp_q.push_back(wa);
    else if (v.rb) exp_q.push_back(wb);
    bus.req_a = v.ra; bus.addr_a = v.aa; bus.data_a = v.da;
    bus.req_b = v.rb; bus.addr_b = v.ab; bus.data_b = v.db;
    cyc = 0;
    while ((bus.req_a || bus.req_b) && cyc < 20) begin
      step();
      cyc++;
      if (bus.gnt_a === 1'b1) bus.req_a = 1'b0;
      if (bus.gnt_b === 1'b1) bus.req_b = 1'b0;
    end
    chk("txn_timeout", {bus.req_a, bus.req_b}, 32'h0);
    clear_inputs();
    step();
    step();
    chk("queue_drained", exp_q.size(), 32'h0);
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    int d0;
    int b0;
    vec_t v;

    vecs[0] = '{1'b1, 2'd2, 8'h5A, 1'b0, 2'd0, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'h33, 1'b0};
    vecs[2] = '{1'b1, 2'd0, 8'h11, 1'b1, 2'd3, 8'h22, 1'b0};
    vecs[3] = '{1'b1, 2'd3, 8'hC3, 1'b0, 2'd0, 8'h00, 1'b0};
    vecs[4] = '{1'b1, 2'd1, 8'h44, 1'b1, 2'd2, 8'h55, 1'b1};
    vecs[5] = '{1'b1, 2'd0, 8'hAA, 1'b1, 2'd1, 8'hBB, 1'b1};

    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset_outputs_initial");

    // Request present at release: no grant on the first edge, grant on the second.
    @(negedge clk);
    rst = 1'b1;
    bus.req_a = 1'b1; bus.addr_a = 2'd1; bus.data_a = 8'h3C;
    exp_q.push_back(mk_wr(2'd1, 8'h3C, 1'b1, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    chk("no_grant_first_edge", {bus.we, bus.gnt_a}, 32'h0);
    step();
    chk("grant_second_edge", bus.gnt_a, 32'h1);
    bus.req_a = 1'b0;
    step();
    step();
    chk("queue_drained_release", exp_q.size(), 32'h0);

    // Table of request vectors from a fresh reset (priority starts at A).
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      if (i == 0) chk("read_reg2", mem[2], 32'h5A);
    end
    chk("mem0_after_table", mem[0], 32'hAA);
    chk("mem1_after_table", mem[1], 32'hBB);
    chk("mem2_after_table", mem[2], 32'h55);
    chk("mem3_after_table", mem[3], 32'hC3);

    // Both requests held continuously: grants alternate on consecutive cycles.
    do_reset();
    bus.req_a = 1'b1; bus.addr_a = 2'd0; bus.data_a = 8'hA0;
    bus.req_b = 1'b1; bus.addr_b = 2'd1; bus.data_b = 8'hB0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk_wr(2'd0, 8'hA0, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(mk_wr(2'd1, 8'hB0, 1'b0, 1'b1, 1'b0));
    end
    repeat (6) step();
    clear_inputs();
    step();
    step();
    chk("queue_drained_alternate", exp_q.size(), 32'h0);
    exp_q.delete();

    // Idle stretch leaves the pointer alone: a tie afterwards still goes to A.
    for (int k = 0; k < 10; k++) begin
      step();
      chk("idle_we", bus.we, 32'h0);
    end
    v = '{1'b1, 2'd2, 8'h12, 1'b1, 2'd3, 8'h34, 1'b0};
    run_vec(v);

    // Clear and req_b together: sweep first, then B in the next grant slot.
    d0 = done_cnt;
    bus.clr_req = 1'b1;
    bus.req_b = 1'b1; bus.addr_b = 2'd2; bus.data_b = 8'h77;
    for (int k = 0; k < 4; k++) exp_q.push_back(mk_wr(AW'(k), 8'h00, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk_wr(2'd2, 8'h77, 1'b0, 1'b1, 1'b0));
    step();
    bus.clr_req = 1'b0;
    chk("clear_wins_no_grant", {bus.busy, bus.gnt_b}, 32'h2);
    cyc = 1;
    while (bus.clr_done !== 1'b1 && cyc < 12) begin
      step();
      cyc++;
    end
    chk("clr_done_latency", cyc, 32'd5);
    chk("done_cycle_busy_we", {bus.busy, bus.we}, 32'h0);
    for (int k = 0; k < 4; k++) chk("mem_zeroed", mem[k], 32'h0);
    step();
    chk("gnt_b_after_clear", bus.gnt_b, 32'h1);
    bus.req_b = 1'b0;
    step();
    step();
    chk("queue_drained_clear", exp_q.size(), 32'h0);
    chk("one_clr_done", done_cnt - d0, 32'd1);
    exp_q.delete();

    // Clear requests mid-sweep and on the clr_done cycle are ignored.
    d0 = done_cnt;
    b0 = busy_cnt;
    bus.clr_req = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(mk_wr(AW'(k), 8'h00, 1'b0, 1'b0, 1'b1));
    step();
    bus.clr_req = 1'b0;
    step();
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    cyc = 3;
    while (bus.clr_done !== 1'b1 && cyc < 12) begin
      step();
      cyc++;
    end
    chk("clr_done_latency_ignored", cyc, 32'd5);
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    repeat (8) step();
    chk("sweep_busy_cycles", busy_cnt - b0, 32'd4);
    chk("single_clr_done", done_cnt - d0, 32'd1);
    chk("queue_drained_ignored", exp_q.size(), 32'h0);
    exp_q.delete();

    // Pointer untouched by the sweep: a tie still goes to A.
    v = '{1'b1, 2'd0, 8'h5C, 1'b1, 2'd1, 8'hC5, 1'b0};
    run_vec(v);

    // Reset two writes into a sweep: no further writes, no clr_done.
    v = '{1'b1, 2'd2, 8'hE2, 1'b0, 2'd0, 8'h00, 1'b0};
    run_vec(v);
    v = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 8'hE3, 1'b0};
    run_vec(v);
    d0 = done_cnt;
    bus.clr_req = 1'b1;
    exp_q.push_back(mk_wr(2'd0, 8'h00, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk_wr(2'd1, 8'h00, 1'b0, 1'b0, 1'b1));
    step();
    bus.clr_req = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk_reset_outputs("reset_mid_sweep");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    repeat (8) step();
    chk("queue_drained_abort", exp_q.size(), 32'h0);
    chk("no_clr_done_after_abort", done_cnt - d0, 32'd0);
    chk("mem0_abort", mem[0], 32'h00);
    chk("mem1_abort", mem[1], 32'h00);
    chk("mem2_kept", mem[2], 32'hE2);
    chk("mem3_kept", mem[3], 32'hE3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter ADDR_W, 2, register address width; the register count is 2**ADDR_W.
REQ-002 Parameter DATA_W, 8, register data width.
REQ-003 Port clk  in  1  the single clock; all state is on its rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-low.
REQ-005 Port req_a  in  1  requester A write request, held high until granted.
REQ-006 Port addr_a  in  ADDR_W  requester A write address, stable while req_a is high.
REQ-007 Port data_a  in  DATA_W  requester A write data, stable while req_a is high.
REQ-008 Port gnt_a  out  1  one-cycle pulse, asserted in the cycle A's write is presented on we/waddr/wdata.
REQ-009 Ports req_b, addr_b, data_b, gnt_b SHALL be identical to the A ports, for requester B.
REQ-010 Port clr_req  in  1  pulse that starts a clear sweep, which writes zero to every register.
REQ-011 Port busy  out  1  high while the clear sweep runs.
REQ-012 Port clr_done  out  1  one-cycle pulse when the sweep completes.
REQ-013 Port we  out  1  write enable to the register-file write port.
REQ-014 Port waddr  out  ADDR_W  write address to the register-file write port.
REQ-015 Port wdata  out  DATA_W  write data to the register-file write port.

Function
REQ-016 States SHALL be IDLE and CLEAR; the clear counter SHALL be ADDR_W bits wide.
REQ-017 All outputs SHALL be registered, so a request sampled at edge N produces we, waddr, wdata and gnt at N+1.
REQ-018 In IDLE with clr_req low, the eligible requesters are the ones whose req is high and whose gnt is not asserted in the current cycle.
REQ-019 With exactly one eligible requester, that requester SHALL be granted.
REQ-020 With both A and B eligible, the round-robin pointer SHALL choose; after a grant, priority SHALL pass to the other requester.
REQ-021 The pointer SHALL change only on a contested grant or an uncontested grant, never on an idle cycle.
REQ-022 On a grant, the next-cycle outputs SHALL be we=1, waddr=addr_x, wdata=data_x and gnt_x=1.
REQ-023 With no eligible requester, the next-cycle outputs SHALL be we=0 and both gnt=0; waddr and wdata SHALL then be 0.
REQ-024 At most one gnt SHALL be high per cycle, and any gnt SHALL coincide with we=1.
REQ-025 When clr_req is high in IDLE, clear wins over any pending req; the block enters CLEAR with counter=0, and no grant occurs that cycle.
REQ-026 In CLEAR, each cycle SHALL output we=1, waddr=counter, wdata=0 and busy=1; the counter SHALL increment once per cycle.
REQ-027 The sweep SHALL last exactly 2**ADDR_W write cycles (4 by default), covering addresses 0 through 2**ADDR_W-1 in ascending order.
REQ-028 The cycle after the last sweep write SHALL show clr_done=1, busy=0 and we=0, with the state back in IDLE; arbitration resumes on the next edge.
REQ-029 A clr_req arriving during CLEAR, or in the clr_done cycle, SHALL be ignored.
REQ-030 Requests held during CLEAR SHALL remain pending and are never lost; the pointer SHALL be unchanged by the sweep.

Reset
REQ-031 Asserting rst SHALL asynchronously force IDLE, counter=0 and pointer=A-priority.
REQ-032 Under reset, we, gnt_a, gnt_b, busy, clr_done, waddr and wdata SHALL all be 0.
REQ-033 A reset during CLEAR SHALL abort the sweep with no further writes, and no clr_done SHALL follow.
REQ-034 The first grant after reset release SHALL occur no earlier than the second rising edge after release.

Structure
REQ-035 Shared package regfile_ctrl_pkg SHALL hold the state enum (IDLE, CLEAR), the requester-ID enum (REQ_A, REQ_B) and the ADDR_W/DATA_W defaults.
REQ-036 One sub-module, rr_arb2, SHALL hold the 2-way round-robin arbiter and its pointer flop.
REQ-037 The block SHALL drive the existing register_file write port directly; the read ports stay outside the block.

Verification
REQ-038 Single request: req_a with addr 2 and data 0x5A -> next cycle we=1, waddr=2, wdata=0x5A and gnt_a=1; read of register 2 returns 0x5A.
REQ-039 Contention from reset: req_a and req_b held high -> grants alternate A, B, A, B on consecutive write cycles, with one gnt per write.
REQ-040 Clear wins: clr_req and req_b rise together -> four writes of 0 to addresses 0, 1, 2, 3 with busy=1, then clr_done; gnt_b follows in the next grant slot.
REQ-041 Ignored clear: clr_req pulsed mid-sweep -> the sweep still lasts exactly 4 write cycles and exactly one clr_done pulse occurs.
REQ-042 Reset mid-sweep: rst low after 2 sweep writes -> all outputs 0 immediately, registers 2 and 3 keep their old values, and no clr_done occurs.
REQ-043 Idle: no req and no clr_req for 10 cycles -> we=0 throughout, and the pointer keeps its value.
